// File: rtl/etpu_wb_master.sv
// Wishbone classic-cycle initiator for the TPU slave window: streams weight and input
// words in as single writes, idles while the TPU runs, then reads back the results.
module etpu_wb_master #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          N_WEIGHT     = 4,
  parameter int          N_INPUT      = 4,
  parameter int          N_RESULT     = 5,
  parameter int          RUN_WAIT     = 32,
  parameter int          TIMEOUT      = 255
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RD    = 3'd5;
  localparam logic [2:0] S_RGAP  = 3'd6;

  localparam int N_WR = N_WEIGHT + N_INPUT;
  localparam int WC_W = $clog2(N_WR + 1);
  localparam int RC_W = $clog2(N_RESULT + 1);
  localparam int WT_W = $clog2(RUN_WAIT + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [WC_W-1:0] WC_END  = WC_W'(N_WR);
  localparam logic [RC_W-1:0] RC_END  = RC_W'(N_RESULT);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(RUN_WAIT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [WC_W-1:0] wc;
  logic [RC_W-1:0] rc;
  logic [WT_W-1:0] wt;
  logic [TO_W-1:0] tcnt;
  logic            bus_active;

  // Bus strobes decode straight from state so an abort or reset drops them at once.
  assign bus_active = (state == S_WR) || (state == S_RD);
  assign wbm_cyc_o  = bus_active;
  assign wbm_stb_o  = bus_active;
  assign wbm_we_o   = (state == S_WR);
  assign wbm_sel_o  = bus_active ? 4'hF : 4'h0;
  assign wbm_adr_o  = bus_active ? BASE_ADDRESS : 32'h0;
  assign wr_ready_o = (state == S_FETCH);
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
    if (caravel_wb_rst_i) begin
      state      <= S_IDLE;
      wc         <= '0;
      rc         <= '0;
      wt         <= '0;
      tcnt       <= '0;
      wbm_dat_o  <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; the case arms below override them for one cycle.
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            wc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (wr_valid_i) begin
            wbm_dat_o <= wr_data_i;
            tcnt      <= '0;
            state     <= S_WR;
          end
        end
        S_WR, S_RD: begin
          if (wbm_ack_i) begin
            if (state == S_WR) begin
              wc    <= wc + WC_W'(1);
              state <= S_GAP;
            end else begin
              rd_data_o  <= wbm_dat_i;
              rd_valid_o <= 1'b1;
              rc         <= rc + RC_W'(1);
              state      <= S_RGAP;
            end
          end else if (tcnt == TO_LAST) begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        // The gap cycle lets the slave's registered ack clear before the next strobe.
        S_GAP: begin
          if (wc < WC_END) begin
            state <= S_FETCH;
          end else begin
            wt    <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wt == WT_LAST) begin
            rc    <= '0;
            tcnt  <= '0;
            state <= S_RD;
          end else begin
            wt <= wt + WT_W'(1);
          end
        end
        S_RGAP: begin
          if (rc < RC_END) begin
            tcnt  <= '0;
            state <= S_RD;
          end else begin
            done_o <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_etpu_wb_master.sv
// Directed bench for etpu_wb_master: a negedge slave model answers the bus and logs
// transfers; the initial block runs reset, nominal, stall, stale-ack, timeout and busy-start jobs.
module tb_etpu_wb_master;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [31:0] wr_data_i = '0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;

  always #5 clk = ~clk;

  etpu_wb_master dut (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (rst),
    .start_i          (start_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .wr_data_i        (wr_data_i),
    .wr_valid_i       (wr_valid_i),
    .wr_ready_o       (wr_ready_o),
    .rd_data_o        (rd_data_o),
    .rd_valid_o       (rd_valid_o),
    .wbm_cyc_o        (wbm_cyc_o),
    .wbm_stb_o        (wbm_stb_o),
    .wbm_we_o         (wbm_we_o),
    .wbm_sel_o        (wbm_sel_o),
    .wbm_adr_o        (wbm_adr_o),
    .wbm_dat_o        (wbm_dat_o),
    .wbm_ack_i        (wbm_ack_i),
    .wbm_dat_i        (wbm_dat_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model and bus monitor, both evaluated at the falling edge.
  int          job_id = 0, mon_job = 0;
  int          ack_len = 1, no_ack_wr = -1;
  int          stb_age = 0, ack_left = 0, last_len = 0;
  bit          cur_we = 1'b0;
  int          cur_idx = 0;
  int          wr_n = 0, rd_n = 0, rv_n = 0, done_n = 0, err_n = 0, bus_bad = 0;
  int          idle_run = 0, idle_before_rd = 0;
  logic [31:0] wr_log [16];
  logic [31:0] rv_log [16];

  always @(negedge clk) begin
    if (mon_job != job_id) begin
      mon_job = job_id;
      wr_n = 0; rd_n = 0; rv_n = 0; done_n = 0; err_n = 0; bus_bad = 0;
      last_len = 0; idle_before_rd = 0;
    end
    if (ack_left > 0) begin
      ack_left--;
      if (ack_left == 0) wbm_ack_i = 1'b0;
    end
    if (wbm_stb_o) begin
      if (stb_age == 0) begin
        cur_we = wbm_we_o;
        if (wbm_we_o) begin
          cur_idx = wr_n;
          if (wr_n < 16) wr_log[wr_n] = wbm_dat_o;
          wr_n++;
        end else begin
          cur_idx = rd_n;
          if (rd_n == 0) idle_before_rd = idle_run;
          rd_n++;
        end
      end
      stb_age++;
      idle_run = 0;
      if (stb_age == 2 && !(cur_we && cur_idx == no_ack_wr)) begin
        wbm_ack_i = 1'b1;
        ack_left  = ack_len;
        if (!cur_we) wbm_dat_i = 32'(cur_idx + 1);
      end
    end else begin
      if (stb_age != 0) last_len = stb_age;
      stb_age = 0;
      idle_run++;
    end
    if (wbm_cyc_o !== wbm_stb_o) bus_bad++;
    if (wbm_stb_o ? (wbm_adr_o !== BASE || wbm_sel_o !== 4'hF)
                  : (wbm_adr_o !== 32'h0 || wbm_sel_o !== 4'h0)) bus_bad++;
    if (rd_valid_o) begin
      if (rv_n < 16) rv_log[rv_n] = rd_data_o;
      rv_n++;
    end
    if (done_o) done_n++;
    if (err_o) err_n++;
  end

  logic [31:0] words [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hA, 32'hB, 32'hC, 32'hD};
  int host_to = 0;

  task automatic begin_job();
    @(posedge clk);
    job_id++;
    host_to = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!wr_ready_o && b < BUDGET) begin
      @(negedge clk);
      b++;
    end
    if (b >= BUDGET) host_to++;
  endtask

  task automatic feed(input int n_words, input int stall_idx);
    for (int i = 0; i < n_words; i++) begin
      if (i == stall_idx) begin
        int st = 0;
        wr_valid_i = 1'b0;
        wait_ready();
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (wbm_stb_o || err_o || !busy_o) st++;
        end
        check("stall_quiet", st, 0);
      end
      wr_data_i  = words[i];
      wr_valid_i = 1'b1;
      wait_ready();
      @(negedge clk);
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_end(input bit poke);
    int b = 0;
    bit seen = 1'b0;
    bit poked = 1'b0;
    while (!seen && b < BUDGET) begin
      @(negedge clk);
      b++;
      start_i = 1'b0;
      if (done_o || err_o) seen = 1'b1;
      else if (poke && !poked && wbm_stb_o && !wbm_we_o) begin
        start_i = 1'b1;
        poked   = 1'b1;
      end
    end
    start_i = 1'b0;
    check("end_seen", 32'(seen), 1);
    if (poke) check("poke_in_rd", 32'(poked), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_full_job(input string tag);
    check({tag, "_wr_n"}, wr_n, 8);
    for (int i = 0; i < 8; i++) check($sformatf("%s_wr%0d", tag, i), wr_log[i], words[i]);
    check({tag, "_rd_n"}, rd_n, 5);
    check({tag, "_rv_n"}, rv_n, 5);
    for (int i = 0; i < 5; i++) check($sformatf("%s_rv%0d", tag, i), rv_log[i], 32'(i + 1));
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_err_n"}, err_n, 0);
    check({tag, "_bus_bad"}, bus_bad, 0);
    check({tag, "_idle_ge32"}, 32'(idle_before_rd >= 32), 1);
    check({tag, "_busy_end"}, 32'(busy_o), 0);
    check({tag, "_host_to"}, host_to, 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_flags", {busy_o, done_o, err_o, wr_ready_o, rd_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat_o", wbm_dat_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    rst = 1'b0;

    // Reset asserted mid-write drops the bus without a clock edge.
    begin
      int b = 0;
      begin_job();
      wr_data_i  = 32'h11;
      wr_valid_i = 1'b1;
      while (!wbm_stb_o && b < BUDGET) begin
        @(negedge clk);
        b++;
      end
      check("midrst_stb_seen", 32'(wbm_stb_o), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_cyc_stb_busy", {wbm_cyc_o, wbm_stb_o, busy_o}, 0);
      wr_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_idle", {busy_o, wr_ready_o, wbm_stb_o}, 0);
    end

    // Nominal job.
    begin_job();
    feed(8, -1);
    wait_end(1'b0);
    check_full_job("nominal");

    // Host stall of 20 cycles before the third word.
    begin_job();
    feed(8, 2);
    wait_end(1'b0);
    check_full_job("stall");

    // Slave leaves ack high one cycle past each strobe.
    ack_len = 2;
    begin_job();
    feed(8, -1);
    wait_end(1'b0);
    check_full_job("stale");
    ack_len = 1;

    // Sixth write never acked: abort after 255 strobe cycles.
    no_ack_wr = 5;
    begin_job();
    feed(6, -1);
    wait_end(1'b0);
    check("to_err_n", err_n, 1);
    check("to_stb_len", last_len, 255);
    check("to_wr_n", wr_n, 6);
    check("to_rd_n", rd_n, 0);
    check("to_rv_n", rv_n, 0);
    check("to_done_n", done_n, 0);
    check("to_bus_idle", {wbm_cyc_o, wbm_stb_o, busy_o}, 0);
    no_ack_wr = -1;

    // Full job after the abort.
    begin_job();
    feed(8, -1);
    wait_end(1'b0);
    check_full_job("after_to");

    // start_i pulsed during a read is ignored.
    begin_job();
    feed(8, -1);
    wait_end(1'b1);
    check_full_job("busy_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
